calc_core: RTL

Parametrised calculator core, the successor to the fixed 4-bit switch/ALU/LED datapath. Operands are entered a 4-bit digit at a time into WIDTH-bit registers. A key-driven FSM launches the operation, and multiply/divide run iteratively. Provides a 2*WIDTH-bit result, valid/busy/error flags and the 3-bit status LED pattern for the seven-segment front end.

---
 rtl/calc_pkg.sv | 49 ++++
 rtl/calc_muldiv.sv | 98 +++++++++
 rtl/calc_core.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator core.
//   - opcode encodings OP_ADD..OP_XOR (8..15 are illegal)
//   - FSM state enum
//   - key codes as seen after synchronisation
//   - status LED patterns
//   - small opcode classification helpers
package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_ITER = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam logic [1:0] KEY_NONE = 2'b00;
  localparam logic [1:0] KEY_A    = 2'b01;
  localparam logic [1:0] KEY_B    = 2'b10;
  localparam logic [1:0] KEY_EXEC = 2'b11;

  localparam logic [2:0] LED_READY   = 3'b110;
  localparam logic [2:0] LED_ENTRY_A = 3'b011;
  localparam logic [2:0] LED_ENTRY_B = 3'b101;
  localparam logic [2:0] LED_BUSY    = 3'b111;
  localparam logic [2:0] LED_ERR     = 3'b000;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_XOR);
  endfunction

  function automatic logic op_is_divmod(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

  function automatic logic op_is_iter(input logic [3:0] op);
    return (op == OP_MUL) || op_is_divmod(op);
  endfunction

endpackage

// File: rtl/calc_muldiv.sv
// calc_muldiv: iterative unsigned multiplier / restoring divider.
//   clk, rst        : clock, synchronous active-high reset (control only)
//   start_i         : one-cycle launch; operands sampled in this cycle
//   div_i           : 0 = multiply a_i*b_i, 1 = divide a_i/b_i
//   a_i, b_i        : WIDTH-bit unsigned operands
//   done_o          : high for one cycle, WIDTH cycles after start_i
//   acc_o           : product, or {remainder, quotient}; valid with done_o
// The first step is folded into the launch cycle so the final value is
// already registered in the cycle done_o is high.
module calc_muldiv
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] acc_o
);

  localparam int RW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [RW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic             div_q, div_d;
  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // acc = {partial product, remaining multiplier bits}
  function automatic logic [RW-1:0] mul_step(input logic [RW-1:0]    acc,
                                             input logic [WIDTH-1:0] mcand);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[RW-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    return {sum, acc[WIDTH-1:1]};
  endfunction

  // acc = {partial remainder, dividend/quotient bits}; a wrapped W-bit
  // difference is exact whenever the trial subtraction succeeds
  function automatic logic [RW-1:0] div_step(input logic [RW-1:0]    acc,
                                             input logic [WIDTH-1:0] dvsr);
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;
    rem_sh = {acc[RW-1:WIDTH], acc[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, dvsr});
    diff   = rem_sh[WIDTH-1:0] - dvsr;
    return ge ? {diff, acc[WIDTH-2:0], 1'b1}
              : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    acc_d = acc_q;
    opd_d = opd_q;
    div_d = div_q;
    run_d = run_q;
    cnt_d = cnt_q;
    if (start_i) begin
      opd_d = div_i ? b_i : a_i;
      div_d = div_i;
      acc_d = div_i ? div_step({{WIDTH{1'b0}}, a_i}, b_i)
                    : mul_step({{WIDTH{1'b0}}, b_i}, a_i);
      run_d = 1'b1;
      cnt_d = CNT_W'(1);
    end else if (run_q) begin
      if (cnt_q == CNT_W'(WIDTH)) begin
        run_d = 1'b0;
      end else begin
        acc_d = div_q ? div_step(acc_q, opd_q) : mul_step(acc_q, opd_q);
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    opd_q <= opd_d;
    div_q <= div_d;
  end

  assign done_o = run_q && (cnt_q == CNT_W'(WIDTH));
  assign acc_o  = acc_q;

endmodule

// File: rtl/calc_core.sv
// calc_core: parametrised calculator core.
//   clk, rst     : clock, synchronous active-high reset
//   in_number    : 4-bit digit from switches
//   arif         : opcode, latched on the execute event
//   key          : 01 shift digit into A, 10 into B, 11 execute
//   result       : 2*WIDTH-bit result of the last completed operation
//   result_valid : result holds a completed operation (DONE)
//   busy         : iterative multiply/divide in progress
//   error        : illegal opcode or divide-by-zero (ERR)
//   led          : status pattern for the display front end
// Build option: define KEY_DEBOUNCE_EN to debounce each synchronised key
// bit for DEB_CYCLES cycles; otherwise DEB_CYCLES only gets range-checked.
module calc_core
  import calc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_number,
  input  logic [3:0]         arif,
  input  logic [1:0]         key,
  output logic [2*WIDTH-1:0] result,
  output logic               result_valid,
  output logic               busy,
  output logic               error,
  output logic [2:0]         led
);

  localparam int RW = 2 * WIDTH;

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("calc_core: WIDTH must be a multiple of 4 and at least 4");
  end
  if (SYNC_STAGES < 1) begin : g_bad_sync
    $error("calc_core: SYNC_STAGES must be at least 1");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("calc_core: DEB_CYCLES must be at least 1");
  end

  logic [1:0] sync_q [SYNC_STAGES];
  logic [1:0] key_s;
  logic [1:0] key_clean;
  logic [1:0] key_prev_q;
  logic       ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= KEY_NONE;
    end else begin
      sync_q[0] <= key;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign key_s = sync_q[SYNC_STAGES-1];

`ifdef KEY_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic [1:0]       deb_q;
  logic [DEB_W-1:0] deb_cnt_q [2];

  // a bit only follows key_s after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= KEY_NONE;
      for (int b = 0; b < 2; b++) deb_cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (key_s[b] == deb_q[b]) begin
          deb_cnt_q[b] <= '0;
        end else if (deb_cnt_q[b] == DEB_W'(DEB_CYCLES - 1)) begin
          deb_q[b]     <= key_s[b];
          deb_cnt_q[b] <= '0;
        end else begin
          deb_cnt_q[b] <= deb_cnt_q[b] + DEB_W'(1);
        end
      end
    end
  end

  assign key_clean = deb_q;
`else
  assign key_clean = key_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) key_prev_q <= KEY_NONE;
    else     key_prev_q <= key_clean;
  end

  // only a release-to-press edge counts; 01->11 without 00 is not an event
  assign ev = (key_prev_q == KEY_NONE) && (key_clean != KEY_NONE);

  function automatic logic [RW-1:0] alu(input logic [3:0]       op,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
    logic        [WIDTH:0] sum;
    logic signed [WIDTH:0] diff;
    sum  = {1'b0, a} + {1'b0, b};
    diff = signed'({1'b0, a}) - signed'({1'b0, b});
    case (op)
      OP_ADD:  return RW'(sum);
      OP_SUB:  return {{(WIDTH-1){diff[WIDTH]}}, diff};
      OP_AND:  return RW'(a & b);
      OP_OR:   return RW'(a | b);
      OP_XOR:  return RW'(a ^ b);
      default: return '0;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [RW-1:0]    result_q, result_d;
  logic [2:0]       idle_led_q, idle_led_d;
  logic             md_start;
  logic             md_div;
  logic             md_done;
  logic [RW-1:0]    md_acc;

  assign md_div = (op_q != OP_MUL);

  calc_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_start),
    .div_i   (md_div),
    .a_i     (a_q),
    .b_i     (b_q),
    .done_o  (md_done),
    .acc_o   (md_acc)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    idle_led_d = idle_led_q;
    md_start   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (ev) begin
          case (key_clean)
            KEY_A: begin
              a_d        = WIDTH'({a_q, in_number});
              idle_led_d = LED_ENTRY_A;
              state_d    = ST_IDLE;
            end
            KEY_B: begin
              b_d        = WIDTH'({b_q, in_number});
              idle_led_d = LED_ENTRY_B;
              state_d    = ST_IDLE;
            end
            KEY_EXEC: begin
              op_d       = arif;
              idle_led_d = LED_READY;
              state_d    = ST_EXEC;
            end
            default: ;
          endcase
        end
      end
      ST_EXEC: begin
        if (!op_is_legal(op_q) || (op_is_divmod(op_q) && b_q == '0)) begin
          result_d = '0;
          state_d  = ST_ERR;
        end else if (op_is_iter(op_q)) begin
          md_start = 1'b1;
          state_d  = ST_ITER;
        end else begin
          result_d = alu(op_q, a_q, b_q);
          state_d  = ST_DONE;
        end
      end
      ST_ITER: begin
        if (md_done) begin
          result_d = (op_q == OP_MOD) ? {{WIDTH{1'b0}}, md_acc[RW-1:WIDTH]}
                                      : md_acc;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      idle_led_q <= LED_READY;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      idle_led_q <= idle_led_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q <= op_d;
  end

  always_comb begin
    case (state_q)
      ST_ITER: led = LED_BUSY;
      ST_DONE: led = LED_READY;
      ST_ERR:  led = LED_ERR;
      default: led = idle_led_q;
    endcase
  end

  assign result       = result_q;
  assign result_valid = (state_q == ST_DONE);
  assign busy         = (state_q == ST_ITER);
  assign error        = (state_q == ST_ERR);

endmodule
